// File: rtl/pop_scheduler_if.sv
// Bundle of FIFO-side and downstream-side signals of pop_scheduler.
// master = the environment (FIFOs + sink), slave = the scheduler.
interface pop_scheduler_if #(
    parameter int unsigned data_width = 10
);
    logic                  init;
    logic                  pause;
    logic                  empty_F0;
    logic                  empty_F1;
    logic                  empty_F2;
    logic                  empty_F3;
    logic [data_width-1:0] data_F0;
    logic [data_width-1:0] data_F1;
    logic [data_width-1:0] data_F2;
    logic [data_width-1:0] data_F3;
    logic                  pop_F0;
    logic                  pop_F1;
    logic                  pop_F2;
    logic                  pop_F3;
    logic [data_width-1:0] data_out;
    logic                  valid_out;
    logic                  IDLE;
    logic [1:0]            state;

    modport master (
        output init, pause,
        output empty_F0, empty_F1, empty_F2, empty_F3,
        output data_F0, data_F1, data_F2, data_F3,
        input  pop_F0, pop_F1, pop_F2, pop_F3,
        input  data_out, valid_out, IDLE, state
    );

    modport slave (
        input  init, pause,
        input  empty_F0, empty_F1, empty_F2, empty_F3,
        input  data_F0, data_F1, data_F2, data_F3,
        output pop_F0, pop_F1, pop_F2, pop_F3,
        output data_out, valid_out, IDLE, state
    );
endinterface

// File: rtl/pop_scheduler.sv
// Four-FIFO pop scheduler: round-robin grant, one pop per cycle, registered output word.
// Define POP_SCHED_STRICT_PRIO_EN for fixed priority F0>F1>F2>F3 instead of round-robin.
module pop_scheduler #(
    parameter int unsigned data_width = 10
) (
    input logic            clk,
    input logic            reset,
    pop_scheduler_if.slave bus
);
    localparam int unsigned NUM_FIFO = 4;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [data_width-1:0] r_data;
    logic                  r_valid;
    logic                  r_idle;

    logic [NUM_FIFO-1:0]   w_empty;
    logic                  w_any;
    logic [IDX_W-1:0]      w_grant;
    logic                  w_grant_vld;
    logic                  w_pop_en;
    logic [NUM_FIFO-1:0]   w_pop;
    logic [data_width-1:0] w_data_sel;

    assign w_empty = {bus.empty_F3, bus.empty_F2, bus.empty_F1, bus.empty_F0};
    assign w_any   = (w_empty != {NUM_FIFO{1'b1}});

`ifdef POP_SCHED_STRICT_PRIO_EN
    // Lowest-numbered non-empty FIFO wins.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_FIFO; k++) begin
            if (!w_grant_vld && !w_empty[k]) begin
                w_grant     = IDX_W'(k);
                w_grant_vld = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] r_last;

    // Search starts just after the last popped FIFO and wraps back to it.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_FIFO; k++) begin
            if (!w_grant_vld && !w_empty[r_last + IDX_W'(k)]) begin
                w_grant     = r_last + IDX_W'(k);
                w_grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= IDX_W'(NUM_FIFO - 1);
        end else if (w_pop_en) begin
            r_last <= w_grant;
        end
    end
`endif

    assign w_pop_en = (r_state == ST_ACTIVE) && !bus.pause && !bus.init && w_grant_vld;
    assign w_pop    = w_pop_en ? (NUM_FIFO'(1) << w_grant) : '0;

    always_comb begin
        w_data_sel = bus.data_F0;
        case (w_grant)
            2'd0: w_data_sel = bus.data_F0;
            2'd1: w_data_sel = bus.data_F1;
            2'd2: w_data_sel = bus.data_F2;
            2'd3: w_data_sel = bus.data_F3;
            default: w_data_sel = bus.data_F0;
        endcase
    end

    // Next-state logic; init overrides everything once past RESET.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!bus.init) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (bus.init)  w_state_nxt = ST_INIT;
                else if (w_any) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.init)   w_state_nxt = ST_INIT;
                else if (!w_any) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
            r_idle  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= (w_state_nxt == ST_IDLE);
            r_valid <= w_pop_en;
            if (w_pop_en) begin
                r_data <= w_data_sel;
            end
        end
    end

    assign bus.pop_F0    = w_pop[0];
    assign bus.pop_F1    = w_pop[1];
    assign bus.pop_F2    = w_pop[2];
    assign bus.pop_F3    = w_pop[3];
    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.IDLE      = r_idle;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_pop_scheduler.sv
// Bench for pop_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_pop_scheduler;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pop_scheduler_if #(.data_width(DW)) bus();
    pop_scheduler #(.data_width(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: FIFO contents, FSM state as plain int, last grant, output word.
    logic [DW-1:0] fq [4][$];
    int            m_state;
    int            m_last;
    logic [DW-1:0] m_data;
    bit            m_valid;
    int            pop_log[$];
    logic [DW-1:0] data_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] head(input int n);
        return (fq[n].size() != 0) ? fq[n][0] : '0;
    endfunction

    function automatic bit all_empty();
        return fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0;
    endfunction

    function automatic int model_grant();
`ifdef POP_SCHED_STRICT_PRIO_EN
        for (int n = 0; n < 4; n++) if (fq[n].size() != 0) return n;
`else
        for (int s = 1; s <= 4; s++) begin
            int n;
            n = (m_last + s) % 4;
            if (fq[n].size() != 0) return n;
        end
`endif
        return -1;
    endfunction

    task automatic drive_inputs();
        bus.empty_F0 = (fq[0].size() == 0);
        bus.empty_F1 = (fq[1].size() == 0);
        bus.empty_F2 = (fq[2].size() == 0);
        bus.empty_F3 = (fq[3].size() == 0);
        bus.data_F0  = head(0);
        bus.data_F1  = head(1);
        bus.data_F2  = head(2);
        bus.data_F3  = head(3);
    endtask

    // One clock: drive at negedge, check outputs, advance the model at posedge.
    task automatic cycle();
        int         g;
        int         nxt;
        bit         any;
        logic [3:0] exp_pop;
        logic [3:0] obs_pop;
        drive_inputs();
        #1;
        chk("state", 32'(bus.state), 32'(m_state));
        chk("IDLE", 32'(bus.IDLE), 32'(m_state == 2));
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        chk("data_out", 32'(bus.data_out), 32'(m_data));
        any     = !all_empty();
        g       = model_grant();
        exp_pop = '0;
        if (m_state == 3 && !bus.pause && !bus.init && g >= 0) exp_pop[g] = 1'b1;
        else g = -1;
        obs_pop = {bus.pop_F3, bus.pop_F2, bus.pop_F1, bus.pop_F0};
        chk("pop", 32'(obs_pop), 32'(exp_pop));
        case (m_state)
            0:       nxt = 1;
            1:       nxt = bus.init ? 1 : 2;
            2:       nxt = bus.init ? 1 : (any ? 3 : 2);
            default: nxt = bus.init ? 1 : (any ? 3 : 2);
        endcase
        @(posedge clk);
        if (g >= 0) begin
            m_data  = fq[g].pop_front();
            m_valid = 1'b1;
            m_last  = g;
            pop_log.push_back(g);
            data_log.push_back(m_data);
        end else begin
            m_valid = 1'b0;
        end
        m_state = nxt;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing mid-cycle.
    task automatic do_reset();
        logic [3:0] obs_pop;
        drive_inputs();
        #2 reset = 1'b0;
        #1;
        obs_pop = {bus.pop_F3, bus.pop_F2, bus.pop_F1, bus.pop_F0};
        chk("rst_pop", 32'(obs_pop), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_IDLE", 32'(bus.IDLE), 32'd0);
        m_state = 0;
        m_last  = 3;
        m_data  = '0;
        m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(all_empty() && m_state == 2) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(all_empty() && m_state == 2), 32'd1);
    endtask

    initial begin
        int exp_seq[8];
        int n;
        reset     = 1'b0;
        bus.init  = 1'b1;
        bus.pause = 1'b0;
        drive_inputs();
        m_state = 0; m_last = 3; m_data = '0; m_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // Power-up: RESET -> INIT held by init -> IDLE.
        bus.init = 1'b1;
        repeat (3) cycle();
        bus.init = 1'b0;
        cycle();
        chk("req030_state", 32'(bus.state), 32'd2);
        chk("req030_IDLE", 32'(bus.IDLE), 32'd1);

`ifndef POP_SCHED_STRICT_PRIO_EN
        // All four FIFOs non-empty: rotating grants.
        for (int f = 0; f < 4; f++) repeat (2) fq[f].push_back(DW'($urandom));
        pop_log.delete();
        repeat (11) cycle();
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk("req031_count", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("req031_order", 32'(pop_log[i]), 32'(exp_seq[i]));
`endif

        // Single FIFO with two known words, then back to IDLE.
        fq[2].push_back(10'h155);
        fq[2].push_back(10'h0AA);
        data_log.delete();
        repeat (6) cycle();
        chk("req032_count", 32'(data_log.size()), 32'd2);
        if (data_log.size() == 2) begin
            chk("req032_w0", 32'(data_log[0]), 32'h155);
            chk("req032_w1", 32'(data_log[1]), 32'h0AA);
        end
        chk("req032_state", 32'(bus.state), 32'd2);

`ifndef POP_SCHED_STRICT_PRIO_EN
        // Pause right after F1 is granted; resume must continue with F2.
        for (int f = 0; f < 4; f++) repeat (3) fq[f].push_back(DW'($urandom));
        pop_log.delete();
        n = 0;
        while (!(pop_log.size() > 0 && pop_log[$] == 1) && n < 20) begin
            cycle();
            n++;
        end
        chk("req033_F1_seen", 32'(pop_log.size() > 0 && pop_log[$] == 1), 32'd1);
        bus.pause = 1'b1;
        n = pop_log.size();
        repeat (3) cycle();
        chk("req033_no_pop", 32'(pop_log.size()), 32'(n));
        chk("req033_valid", 32'(bus.valid_out), 32'd0);
        bus.pause = 1'b0;
        cycle();
        chk("req033_next", 32'(pop_log[$]), 32'd2);
`endif

        // init in ACTIVE stops popping at once and forces INIT.
        for (int f = 0; f < 4; f++) fq[f].push_back(DW'($urandom));
        bus.init = 1'b0;
        n = 0;
        while (m_state != 3 && n < 10) begin cycle(); n++; end
        chk("req034_active", 32'(m_state), 32'd3);
        bus.init = 1'b1;
        cycle();
        chk("req034_state", 32'(bus.state), 32'd1);
        bus.init = 1'b0;
        drain(60);

`ifdef POP_SCHED_STRICT_PRIO_EN
        // Fixed priority: F0 drains fully before F3.
        fq[0].push_back(10'h001); fq[0].push_back(10'h002); fq[0].push_back(10'h003);
        fq[3].push_back(10'h3F0);
        pop_log.delete();
        drain(20);
        exp_seq = '{0, 0, 0, 3, 0, 0, 0, 0};
        chk("req035_count", 32'(pop_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("req035_order", 32'(pop_log[i]), 32'(exp_seq[i]));
`endif

        // Random traffic with occasional pause, init and asynchronous reset.
        for (int it = 0; it < 400; it++) begin
            for (int f = 0; f < 4; f++)
                if ($urandom_range(0, 9) < 3 && fq[f].size() < 6) fq[f].push_back(DW'($urandom));
            bus.pause = ($urandom_range(0, 4) == 0);
            bus.init  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end
        bus.pause = 1'b0;
        bus.init  = 1'b0;
        drain(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
